dvp_frame_tx: RTL and testbench
===============================

Name: dvp_frame_tx

Overview:
- Transmitter end of the OV7670-style DVP pixel bus: reads a 12-bit RGB444 frame buffer and drives pclk, vsync, href and 8-bit data.
- Byte order and sync polarity match the camera capture path.
- Used as a camera emulator, so the capture path can be looped back and verified without a sensor.
- Also used as a DVP output port for the frame buffer read side.

Parameters:
- H_ACTIVE, 320, active pixels per line (2 bytes each)
- V_ACTIVE, 240, active lines per frame
- H_BLANK, 144, byte periods with href low after each line's active bytes
- VSYNC_LINES, 3, lines with vsync high at frame start
- V_BACK, 17, blank lines after vsync, before the first active line
- V_FRONT, 10, blank lines after the last active line
- CLK_DIV, 4, clk cycles per byte period; even, >= 2
- ADDR_W, 17, frame buffer address width; H_ACTIVE*V_ACTIVE <= 2^ADDR_W

Ports:
- clk, input, 1, system clock (clk_100 domain)
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, level: frames are sent while high
- pix_rd, output, 1, one-cycle frame buffer read strobe
- pix_addr, output, ADDR_W, frame buffer read address
- pix_data, input, 12, {R,G,B} 4 bits each; valid exactly 1 clk after pix_rd
- pclk, output, 1, generated pixel clock
- vsync, output, 1, high = frame sync / idle
- href, output, 1, high during active bytes
- d, output, 8, DVP data
- busy, output, 1, high from leaving IDLE until the end of the frame
- frame_done, output, 1, one-cycle pulse after the last V_FRONT byte

Behaviour:
- Reset (async, rst_n low):
  - pclk=0, vsync=1, href=0, d=0, pix_rd=0, pix_addr=0, busy=0, frame_done=0.
  - State=IDLE, all counters cleared; applies immediately, including mid-frame.
- Divider:
  - div counter runs 0..CLK_DIV-1 continuously.
  - pclk=0 while div < CLK_DIV/2, else 1.
  - vsync, href and d update only on the clk edge where div wraps to 0 (pclk falling), so they are stable at pclk rising edges.
- Line timing:
  - Each line is 2*H_ACTIVE + H_BLANK byte periods.
  - A byte counter runs 0..line_len-1; a line counter steps at each line end.
- States, advancing at byte-period boundaries:
  - IDLE: vsync=1, href=0, d=0. If start=1 at a div wrap, go to VSYNC and load pix_addr=0.
  - VSYNC: vsync=1 for VSYNC_LINES lines, then go to VBACK.
  - VBACK: vsync=0, href=0 for V_BACK lines, then go to ACTIVE.
  - ACTIVE (V_ACTIVE lines):
    - Bytes 0..2*H_ACTIVE-1: href=1, d alternates even byte = pix[11:4] and odd byte = {pix[3:0],4'b0}.
    - Remaining H_BLANK bytes: href=0, d=0.
    - After the last line, go to VFRONT.
  - VFRONT: V_FRONT blank lines. Then pulse frame_done for 1 clk.
    - If start=1, go straight to VSYNC with pix_addr=0 and busy held high.
    - Otherwise go to IDLE, busy=0.
- Pixel fetch:
  - pix_rd fires at div==0 of each odd-byte period of the ACTIVE region, except the last pixel of a line.
  - It also fires at div==0 of the last byte period before each ACTIVE line: last H_BLANK byte, or last VBACK byte for line 0.
  - pix_data is registered 1 clk later and used from the next even byte.
  - pix_addr increments by 1 on the cycle after each pix_rd.
  - Exactly H_ACTIVE*V_ACTIVE reads per frame; pix_addr ends at H_ACTIVE*V_ACTIVE and is reloaded to 0 on VSYNC entry.
- Start behaviour:
  - start is sampled only in IDLE and at the VFRONT end.
  - Deasserting start mid-frame does not truncate the frame.
- busy=1 in every state except IDLE.
- Width rules: byte counter is clog2(line_len) bits, line counter clog2(max lines) bits; no wrap inside a frame.

Test Plan:
Shared setup for every scenario: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, CLK_DIV=2, so line_len=11 bytes (22 clk) and frame=55 bytes (110 clk).
1. Reset values: hold rst_n=0 with start=1 -> vsync=1, pclk=0, href=0, d=0, busy=0, pix_rd=0. Release -> VSYNC entered on the first div wrap.
2. Single frame: pulse start for 1 frame, with a memory model returning pix_data=addr*0x111 -> vsync high for 22 clk. href shows 2 pulses of 8 bytes. Line 0 d = 00,00,11,10,22,20,33,30. frame_done pulses once at ~110 clk after start. busy falls with it; pix_rd count = 8.
3. Continuous: hold start=1 for 3 frames -> busy stays 1, frame_done pulses every 110 clk, pix_addr returns to 0 at each VSYNC entry.
4. Mid-frame stop: drop start during the ACTIVE region -> the frame completes with all 8 pixels, then IDLE (vsync=1, busy=0).
5. Async reset mid-line: assert rst_n=0 during href=1 -> outputs go to reset values in the same cycle without a clock. After release with start=1, the next frame starts from pix_addr=0.
6. Loopback: connect to the capture FSM with pclk driving the capture clock and a full-size 320x240 frame -> captured RGB444 words equal the source buffer at the capture addresses, with no byte-order swap.

Source files
------------

// File: rtl/dvp_frame_tx.sv
// DVP (OV7670-style) pixel bus transmitter: streams an RGB444 frame buffer as
// pclk/vsync/href/d, high byte of each pixel first.
module dvp_frame_tx #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int CLK_DIV     = 4,
  parameter int ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [11:0]       pix_data,
  output logic              pclk,
  output logic              vsync,
  output logic              href,
  output logic [7:0]        d,
  output logic              busy,
  output logic              frame_done
);

  localparam int LINE_LEN = 2*H_ACTIVE + H_BLANK;
  localparam int MAX_AB   = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int MAX_CD   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_L    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int BYTE_W   = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int LINE_W   = (MAX_L > 1) ? $clog2(MAX_L) : 1;
  localparam int DIV_W    = $clog2(CLK_DIV);

  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(LINE_LEN-1);
  localparam logic [BYTE_W-1:0] ACT_BYTES = BYTE_W'(2*H_ACTIVE);
  localparam logic [BYTE_W-1:0] LAST_ODD  = BYTE_W'(2*H_ACTIVE-1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div;
  logic [BYTE_W-1:0] r_byteCnt;
  logic [LINE_W-1:0] r_lineCnt;
  logic [11:0]       r_pix;
  logic              r_rdDly;

  state_t            w_nState;
  logic [BYTE_W-1:0] w_nByte;
  logic [LINE_W-1:0] w_nLine;
  logic [DIV_W-1:0]  w_divNext;
  logic              w_wrap;
  logic              w_lineEnd;
  logic              w_lastLine;
  logic              w_frameEnd;
  logic              w_startFrame;
  logic              w_activeByte;
  logic              w_fetch;
  logic [11:0]       w_pix;
  logic [7:0]        w_dNext;

  // Next byte-period position; only committed on the edge where div wraps.
  always_comb begin
    w_wrap     = (r_div == DIV_W'(CLK_DIV-1));
    w_divNext  = w_wrap ? '0 : r_div + DIV_W'(1);
    w_lineEnd  = (r_byteCnt == LAST_BYTE);
    w_nState   = r_state;
    w_nByte    = r_byteCnt;
    w_nLine    = r_lineCnt;
    w_frameEnd = 1'b0;
    case (r_state)
      VSYNC:   w_lastLine = (r_lineCnt == LINE_W'(VSYNC_LINES-1));
      VBACK:   w_lastLine = (r_lineCnt == LINE_W'(V_BACK-1));
      ACTIVE:  w_lastLine = (r_lineCnt == LINE_W'(V_ACTIVE-1));
      VFRONT:  w_lastLine = (r_lineCnt == LINE_W'(V_FRONT-1));
      default: w_lastLine = 1'b0;
    endcase
    if (r_state == IDLE) begin
      if (start) begin
        w_nState = VSYNC;
        w_nByte  = '0;
        w_nLine  = '0;
      end
    end else if (w_lineEnd) begin
      w_nByte = '0;
      if (w_lastLine) begin
        w_nLine = '0;
        case (r_state)
          VSYNC:  w_nState = VBACK;
          VBACK:  w_nState = ACTIVE;
          ACTIVE: w_nState = VFRONT;
          VFRONT: begin
            w_frameEnd = 1'b1;
            w_nState   = start ? VSYNC : IDLE;
          end
          default: w_nState = IDLE;
        endcase
      end else begin
        w_nLine = r_lineCnt + LINE_W'(1);
      end
    end else begin
      w_nByte = r_byteCnt + BYTE_W'(1);
    end

    w_startFrame = (w_nState == VSYNC) && (r_state != VSYNC);
    w_activeByte = (w_nState == ACTIVE) && (w_nByte < ACT_BYTES);
    // Prefetch the next pixel on odd bytes, or in the last byte before a line.
    w_fetch = ((w_nState == ACTIVE) && w_nByte[0] && (w_nByte < LAST_ODD)) ||
              ((w_nState == ACTIVE) && (w_nByte == LAST_BYTE) &&
               (w_nLine != LINE_W'(V_ACTIVE-1))) ||
              ((w_nState == VBACK) && (w_nByte == LAST_BYTE) &&
               (w_nLine == LINE_W'(V_BACK-1)));
    // With CLK_DIV=2 the read data arrives on the same edge it is first needed.
    w_pix   = r_rdDly ? pix_data : r_pix;
    w_dNext = !w_activeByte ? 8'h00 :
              (w_nByte[0] ? {w_pix[3:0], 4'h0} : w_pix[11:4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_byteCnt  <= '0;
      r_lineCnt  <= '0;
      r_pix      <= '0;
      r_rdDly    <= 1'b0;
      pclk       <= 1'b0;
      vsync      <= 1'b1;
      href       <= 1'b0;
      d          <= '0;
      pix_rd     <= 1'b0;
      pix_addr   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_div      <= w_divNext;
      pclk       <= (w_divNext >= DIV_W'(CLK_DIV/2));
      r_rdDly    <= pix_rd;
      pix_rd     <= w_wrap && w_fetch;
      frame_done <= w_wrap && w_frameEnd;
      if (r_rdDly) r_pix <= pix_data;
      if (w_wrap && w_startFrame) pix_addr <= '0;
      else if (pix_rd)            pix_addr <= pix_addr + ADDR_W'(1);
      if (w_wrap) begin
        r_state   <= w_nState;
        r_byteCnt <= w_nByte;
        r_lineCnt <= w_nLine;
        vsync     <= (w_nState == IDLE) || (w_nState == VSYNC);
        href      <= w_activeByte;
        d         <= w_dNext;
        busy      <= (w_nState != IDLE);
      end
    end
  end

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Directed bench for dvp_frame_tx using a tiny 4x2 frame (11-byte lines,
// 55-byte frames at 2 clk per byte) and a frame buffer returning addr*0x111.
module tb_dvp_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        pixRd;
  logic [16:0] pixAddr;
  logic [11:0] pixData = '0;
  logic        pclk;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        busy;
  logic        frameDone;

  int checkCount = 0;
  int errorCount = 0;

  logic       capEn = 1'b0;
  logic [7:0] capQ[$];

  dvp_frame_tx #(
    .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(3), .VSYNC_LINES(1),
    .V_BACK(1), .V_FRONT(1), .CLK_DIV(2), .ADDR_W(17)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pix_rd(pixRd), .pix_addr(pixAddr), .pix_data(pixData),
    .pclk(pclk), .vsync(vsync), .href(href), .d(d),
    .busy(busy), .frame_done(frameDone)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pixRd) pixData <= pixAddr[11:0] * 12'h111;

  always @(posedge pclk) if (capEn && href) capQ.push_back(d);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input int cycles);
    start = st;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int firstVsyncLow, firstDone, doneCnt, rdCnt, hrefPulses, busyAtDone;
    int t[4];
    int busyLow, firstAddr;
    logic prevHref, stopped, gotDone, seen;
    logic [11:0] v;

    // Reset held with start high
    rst_n = 1'b0;
    applyStimulus(1'b1, 3);
    checkOutput("rst_vsync", vsync, 1);
    checkOutput("rst_pclk", pclk, 0);
    checkOutput("rst_href", href, 0);
    checkOutput("rst_d", d, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pixrd", pixRd, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_busy_p1", busy, 0);
    @(negedge clk);
    checkOutput("rel_busy_p2", busy, 1);
    checkOutput("rel_vsync_p2", vsync, 1);

    // Single frame, start dropped right after VSYNC entry
    start = 1'b0;
    capQ.delete();
    capEn = 1'b1;
    firstVsyncLow = -1; firstDone = -1; doneCnt = 0; rdCnt = 0;
    hrefPulses = 0; busyAtDone = -1; prevHref = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (!vsync && firstVsyncLow < 0) firstVsyncLow = k;
      if (pixRd) rdCnt++;
      if (href && !prevHref) hrefPulses++;
      prevHref = href;
      if (frameDone) begin
        doneCnt++;
        if (firstDone < 0) begin firstDone = k; busyAtDone = int'(busy); end
      end
    end
    capEn = 1'b0;
    checkOutput("s2_vsync_len", firstVsyncLow, 22);
    checkOutput("s2_done_time", firstDone, 110);
    checkOutput("s2_done_count", doneCnt, 1);
    checkOutput("s2_busy_at_done", busyAtDone, 0);
    checkOutput("s2_rd_count", rdCnt, 8);
    checkOutput("s2_href_pulses", hrefPulses, 2);
    checkOutput("s2_addr_end", pixAddr, 8);
    checkOutput("s2_idle_vsync", vsync, 1);
    checkOutput("s2_idle_busy", busy, 0);
    checkOutput("s2_byte_count", capQ.size(), 16);
    for (int i = 0; i < 16 && i < capQ.size(); i++) begin
      v = 12'(i / 2) * 12'h111;
      checkOutput($sformatf("s2_byte%0d", i), capQ[i],
                  (i % 2 == 0) ? 32'(v[11:4]) : 32'({v[3:0], 4'h0}));
    end

    // Continuous frames, start held for two frame ends
    start = 1'b1;
    doneCnt = 0; rdCnt = 0; busyLow = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (pixRd) rdCnt++;
      if (doneCnt >= 1 && !frameDone && !busy) busyLow++;
      if (frameDone) begin
        doneCnt++;
        t[doneCnt] = k;
        if (doneCnt <= 2) checkOutput($sformatf("s3_addr_reload%0d", doneCnt), pixAddr, 0);
        if (doneCnt == 2) start = 1'b0;
        if (doneCnt == 3) break;
      end
    end
    checkOutput("s3_done_count", doneCnt, 3);
    checkOutput("s3_period1", t[2] - t[1], 110);
    checkOutput("s3_period2", t[3] - t[2], 110);
    checkOutput("s3_busy_low", busyLow, 0);
    checkOutput("s3_rd_count", rdCnt, 24);
    checkOutput("s3_end_busy", busy, 0);

    // Start dropped in the middle of ACTIVE
    start = 1'b1;
    rdCnt = 0; stopped = 1'b0; gotDone = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (pixRd) rdCnt++;
      if (href && !stopped) begin start = 1'b0; stopped = 1'b1; end
      if (frameDone) begin gotDone = 1'b1; break; end
    end
    checkOutput("s4_stopped", stopped, 1);
    checkOutput("s4_done", gotDone, 1);
    checkOutput("s4_rd_count", rdCnt, 8);
    repeat (3) @(negedge clk);
    checkOutput("s4_idle_vsync", vsync, 1);
    checkOutput("s4_idle_busy", busy, 0);

    // Asynchronous reset while href is high
    start = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 300 && !seen; k++) begin
      @(negedge clk);
      if (href) seen = 1'b1;
    end
    checkOutput("s5_href_seen", seen, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("s5_href", href, 0);
    checkOutput("s5_vsync", vsync, 1);
    checkOutput("s5_d", d, 0);
    checkOutput("s5_busy", busy, 0);
    checkOutput("s5_addr", pixAddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0; firstAddr = -1; rdCnt = 0; gotDone = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (pixRd) begin
        if (!seen) begin firstAddr = int'(pixAddr); seen = 1'b1; end
        rdCnt++;
      end
      if (frameDone) begin gotDone = 1'b1; break; end
    end
    start = 1'b0;
    checkOutput("s5_first_addr", firstAddr, 0);
    checkOutput("s5_rd_count", rdCnt, 8);
    checkOutput("s5_done", gotDone, 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
